// File: rtl/arb_mux_n_pkg.sv
// Shared constants and types for the arbitrating multiplexer.
// Holds the arbitration mode codes, the output stage state type and the select-width helper.
package arb_mux_n_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational grant logic plus the round-robin priority pointer.
// Produces a one-hot grant and its binary index; the pointer moves only on a transfer.
module rr_arbiter_n
    import arb_mux_n_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MODE     = ARB_RR,
    parameter int SELW     = sel_width(CHANNELS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     grant_idx
);

    logic [SELW-1:0]     ptr;
    logic [CHANNELS-1:0] above_ptr;
    logic [CHANNELS-1:0] masked;
    logic [CHANNELS-1:0] pool;

    // Channels strictly above the last winner get first chance; fixed mode never masks.
    always_comb begin
        above_ptr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            above_ptr[i] = (MODE == ARB_RR) && (i > int'(ptr));
        end
    end

    assign masked = req & above_ptr;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        pool      = (|masked) ? masked : req;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pool[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = SELW'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= SELW'(CHANNELS - 1);
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// Registered N-channel arbitrating multiplexer with valid/ready on every side.
// The arbiter picks a requester; the winning word sits in the output register until accepted.
module arb_mux_n
    import arb_mux_n_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int CHANNELS = 4,
    parameter int MODE     = ARB_RR,
    parameter int SELW     = sel_width(CHANNELS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CHANNELS*BITS-1:0] IN_DATA,
    input  logic [CHANNELS-1:0]      IN_VALID,
    output logic [CHANNELS-1:0]      IN_READY,
    output logic [BITS-1:0]          OUT_DATA,
    output logic [SELW-1:0]          OUT_SEL,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY
);

    stage_t              state;
    stage_t              state_next;
    logic                load_en;
    logic                xfer;
    logic [CHANNELS-1:0] grant;
    logic [SELW-1:0]     grant_idx;

    rr_arbiter_n #(
        .CHANNELS (CHANNELS),
        .MODE     (MODE),
        .SELW     (SELW)
    ) u_arbiter (
        .CLK       (CLK),
        .RST       (RST),
        .req       (IN_VALID),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The stage accepts when empty, or when full and being drained this cycle.
    assign load_en  = (state == ST_EMPTY) || OUT_READY;
    assign IN_READY = (load_en && !RST) ? grant : '0;
    assign xfer     = |IN_READY;

    always_comb begin
        state_next = state;
        if (xfer) begin
            state_next = ST_FULL;
        end else if (OUT_READY) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_DATA <= '0;
            OUT_SEL  <= '0;
        end else if (xfer) begin
            OUT_DATA <= IN_DATA[int'(grant_idx)*BITS +: BITS];
            OUT_SEL  <= grant_idx;
        end
    end

    assign OUT_VALID = (state == ST_FULL);

    a_ready_onehot : assert property (@(posedge CLK) disable iff (RST) $onehot0(IN_READY));
    a_ready_needs_valid : assert property (@(posedge CLK) disable iff (RST) (IN_READY & ~IN_VALID) == '0);

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: a fixed-priority and a round-robin instance, each with its own producers.
// Hand-derived vector table for the directed cases plus randomized traffic against a queue-free model.
module tb_arb_mux_n;

    logic        clk;
    logic        rst;
    logic [15:0] in_data   [2];
    logic [3:0]  in_valid  [2];
    logic [3:0]  in_ready  [2];
    logic [3:0]  out_data  [2];
    logic [1:0]  out_sel   [2];
    logic        out_valid [2];
    logic        out_ready [2];

    int n_pass;
    int n_total;

    // Reference model state: index 0 is the fixed-priority instance, index 1 round-robin.
    int m_valid [2];
    int m_data  [2];
    int m_sel   [2];
    int m_last  [2];
    int acc     [2];

    typedef struct {
        logic        rst;
        int          inst;
        logic [3:0]  valid;
        logic [15:0] data;
        logic        ordy;
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [3:0]  e_data;
        logic [1:0]  e_sel;
    } vec_t;

    vec_t tbl[$];

    arb_mux_n #(.BITS(4), .CHANNELS(4), .MODE(0)) u_fixed (
        .CLK       (clk),
        .RST       (rst),
        .IN_DATA   (in_data[0]),
        .IN_VALID  (in_valid[0]),
        .IN_READY  (in_ready[0]),
        .OUT_DATA  (out_data[0]),
        .OUT_SEL   (out_sel[0]),
        .OUT_VALID (out_valid[0]),
        .OUT_READY (out_ready[0])
    );

    arb_mux_n #(.BITS(4), .CHANNELS(4), .MODE(1)) u_rr (
        .CLK       (clk),
        .RST       (rst),
        .IN_DATA   (in_data[1]),
        .IN_VALID  (in_valid[1]),
        .IN_READY  (in_ready[1]),
        .OUT_DATA  (out_data[1]),
        .OUT_SEL   (out_sel[1]),
        .OUT_VALID (out_valid[1]),
        .OUT_READY (out_ready[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input int inst, input logic [3:0] v,
                                input logic [15:0] d, input logic o, input logic [3:0] er,
                                input logic ev, input logic [3:0] ed, input logic [1:0] es);
        vec_t t;
        t.rst = r; t.inst = inst; t.valid = v; t.data = d; t.ordy = o;
        t.e_ready = er; t.e_valid = ev; t.e_data = ed; t.e_sel = es;
        return t;
    endfunction

    task automatic model_reset(input int m);
        m_valid[m] = 0;
        m_data[m]  = 0;
        m_sel[m]   = 0;
        m_last[m]  = 3;
    endtask

    // Winner by the arbitration rules: lowest index, or first valid after the last winner.
    function automatic int pick(input int m, input logic [3:0] v);
        if (m == 0) begin
            for (int i = 0; i < 4; i++) if (v[i]) return i;
            return -1;
        end
        for (int k = 1; k <= 4; k++) if (v[(m_last[m] + k) % 4]) return (m_last[m] + k) % 4;
        return -1;
    endfunction

    task automatic drive(input int inst, input logic [3:0] v, input logic [15:0] d, input logic o);
        for (int m = 0; m < 2; m++) begin
            in_valid[m]  = (m == inst) ? v : 4'h0;
            in_data[m]   = (m == inst) ? d : 16'h0;
            out_ready[m] = (m == inst) ? o : 1'b0;
        end
    endtask

    // Called just after a falling edge with inputs settled; returns just after the next one.
    task automatic cycle();
        int         w [2];
        logic [3:0] er;
        #1;
        for (int m = 0; m < 2; m++) begin
            if (rst) model_reset(m);
            w[m] = -1;
            er   = 4'h0;
            if (!rst && (m_valid[m] == 0 || out_ready[m])) w[m] = pick(m, in_valid[m]);
            if (w[m] >= 0) er = 4'(1 << w[m]);
            check($sformatf("m%0d in_ready", m), in_ready[m], er);
            check($sformatf("m%0d out_valid", m), out_valid[m], m_valid[m]);
            check($sformatf("m%0d out_data", m), out_data[m], m_data[m]);
            check($sformatf("m%0d out_sel", m), out_sel[m], m_sel[m]);
            acc[m] = w[m];
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                model_reset(m);
            end else if (w[m] >= 0) begin
                m_valid[m] = 1;
                m_data[m]  = int'(in_data[m][w[m]*4 +: 4]);
                m_sel[m]   = w[m];
                m_last[m]  = w[m];
            end else if (out_ready[m]) begin
                m_valid[m] = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        drive(0, 4'h0, 16'h0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            model_reset(m);
            acc[m] = -1;
        end

        // Reset with all requests up, then round-robin fairness and wrap on the RR instance.
        tbl.push_back(mk(1, 1, 4'hF, 16'hDCBA, 1, 4'b0000, 0, 4'h0, 2'd0));
        tbl.push_back(mk(1, 1, 4'hF, 16'hDCBA, 1, 4'b0000, 0, 4'h0, 2'd0));
        tbl.push_back(mk(0, 1, 4'hF, 16'hDCBA, 1, 4'b0001, 0, 4'h0, 2'd0));
        tbl.push_back(mk(0, 1, 4'hF, 16'hDCBA, 1, 4'b0010, 1, 4'hA, 2'd0));
        tbl.push_back(mk(0, 1, 4'hF, 16'hDCBA, 1, 4'b0100, 1, 4'hB, 2'd1));
        tbl.push_back(mk(0, 1, 4'hF, 16'hDCBA, 1, 4'b1000, 1, 4'hC, 2'd2));
        tbl.push_back(mk(0, 1, 4'hF, 16'hDCBA, 1, 4'b0001, 1, 4'hD, 2'd3));
        tbl.push_back(mk(0, 1, 4'hF, 16'hDCBA, 1, 4'b0010, 1, 4'hA, 2'd0));
        // Fixed priority: channel 1 starves channel 3 until it drops; then drain to empty.
        tbl.push_back(mk(0, 0, 4'hA, 16'h9050, 1, 4'b0010, 0, 4'h0, 2'd0));
        tbl.push_back(mk(0, 0, 4'hA, 16'h9050, 1, 4'b0010, 1, 4'h5, 2'd1));
        tbl.push_back(mk(0, 0, 4'hA, 16'h9050, 1, 4'b0010, 1, 4'h5, 2'd1));
        tbl.push_back(mk(0, 0, 4'h8, 16'h9050, 1, 4'b1000, 1, 4'h5, 2'd1));
        tbl.push_back(mk(0, 0, 4'h0, 16'h9050, 1, 4'b0000, 1, 4'h9, 2'd3));
        tbl.push_back(mk(0, 0, 4'h0, 16'h0000, 1, 4'b0000, 0, 4'h9, 2'd3));
        tbl.push_back(mk(0, 0, 4'h0, 16'h0000, 1, 4'b0000, 0, 4'h9, 2'd3));
        // Backpressure: load 0x7 from channel 2, stall five cycles, then drain and load together.
        tbl.push_back(mk(0, 0, 4'h4, 16'h0700, 0, 4'b0100, 0, 4'h9, 2'd3));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(0, 0, 4'hF, 16'h3210, 0, 4'b0000, 1, 4'h7, 2'd2));
        end
        tbl.push_back(mk(0, 0, 4'h1, 16'h000E, 1, 4'b0001, 1, 4'h7, 2'd2));
        tbl.push_back(mk(0, 0, 4'h0, 16'h0000, 0, 4'b0000, 1, 4'hE, 2'd0));
        tbl.push_back(mk(0, 0, 4'h0, 16'h0000, 1, 4'b0000, 1, 4'hE, 2'd0));
        tbl.push_back(mk(0, 0, 4'h0, 16'h0000, 0, 4'b0000, 0, 4'hE, 2'd0));

        @(negedge clk);
        foreach (tbl[k]) begin
            rst = tbl[k].rst;
            drive(tbl[k].inst, tbl[k].valid, tbl[k].data, tbl[k].ordy);
            #1;
            check($sformatf("tbl%0d in_ready", k), in_ready[tbl[k].inst], tbl[k].e_ready);
            check($sformatf("tbl%0d out_valid", k), out_valid[tbl[k].inst], tbl[k].e_valid);
            check($sformatf("tbl%0d out_data", k), out_data[tbl[k].inst], tbl[k].e_data);
            check($sformatf("tbl%0d out_sel", k), out_sel[tbl[k].inst], tbl[k].e_sel);
            cycle();
        end

        // Asynchronous reset while the RR instance holds a word from channel 2 (pointer at 2).
        rst = 1'b1;
        drive(1, 4'h0, 16'h0, 1'b0);
        cycle();
        rst = 1'b0;
        drive(1, 4'h4, 16'h0700, 1'b0);
        cycle();
        drive(1, 4'h0, 16'h0, 1'b0);
        #1;
        check("mid_rst pre out_valid", out_valid[1], 1'b1);
        check("mid_rst pre out_data", out_data[1], 4'h7);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst out_valid", out_valid[1], 1'b0);
        check("mid_rst out_data", out_data[1], 4'h0);
        check("mid_rst in_ready", in_ready[1], 4'h0);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        drive(1, 4'hF, 16'hDCBA, 1'b1);
        #1;
        check("post_rst first grant", in_ready[1], 4'b0001);
        cycle();
        #1;
        check("post_rst out_sel", out_sel[1], 2'd0);
        check("post_rst out_data", out_data[1], 4'hA);
        cycle();

        // Randomized traffic; producers hold a request until it is accepted.
        for (int n = 0; n < 400; n++) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 4; i++) begin
                    if (!in_valid[m][i] || acc[m] == i) begin
                        in_valid[m][i]       = 1'($urandom_range(0, 1));
                        in_data[m][i*4 +: 4] = 4'($urandom);
                    end
                end
                out_ready[m] = ($urandom_range(0, 9) < 7);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Registered N-channel arbitrating multiplexer with valid/ready handshake on every input and on the output. It replaces hand-instantiated fixed-width select muxes wherever several producers share one consumer, such as spawner, gravity tick and player move requests feeding the single board-update port. Selection is made internally by a fixed-priority or round-robin arbiter rather than by an external SEL. The winning word is held in an output register until the consumer accepts it.

## Interface
- BITS, 4: data width per channel (1..32)
- CHANNELS, 4: number of input channels (2..8)
- MODE, 1: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round-robin
- SELW, derived: $clog2(CHANNELS); not overridden by users
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- IN_DATA  in  CHANNELS*BITS  packed inputs; channel i occupies [i*BITS +: BITS]
- IN_VALID  in  CHANNELS  per-channel request
- IN_READY  out  CHANNELS  per-channel accept (one-hot or zero)
- OUT_DATA  out  BITS  registered selected word
- OUT_SEL  out  SELW  index of the channel that supplied OUT_DATA
- OUT_VALID  out  1  OUT_DATA/OUT_SEL hold a word
- OUT_READY  in  1  consumer accepts the word

## Operation
- Output stage has two states, EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
- load_en = !OUT_VALID || OUT_READY. The stage can take a new word when it is empty, or when it is full and being drained in the same cycle.
- The grant is computed combinationally from IN_VALID and the priority pointer.
  - Exactly one channel is granted when any IN_VALID is high and load_en=1.
- IN_READY[i] = load_en && grant[i]. A transfer on channel i happens on IN_VALID[i] && IN_READY[i].
- On transfer, at the next edge:
  - OUT_DATA <= IN_DATA[i]
  - OUT_SEL <= i
  - OUT_VALID <= 1
- On OUT_READY && OUT_VALID with no incoming transfer, OUT_VALID <= 0. OUT_DATA and OUT_SEL hold their last values.
- Simultaneous drain and load: the new word replaces the old in the same edge, OUT_VALID stays 1, and no bubble is inserted.
- FULL with OUT_READY=0: all IN_READY are 0, and OUT_DATA/OUT_SEL/OUT_VALID are stable (no change while stalled).
- Fixed priority (MODE=0): the lowest-index valid channel wins, and the pointer is unused.
- Round-robin (MODE=1):
  - The search starts at ptr+1 modulo CHANNELS and takes the first valid channel.
  - On each transfer, ptr <= granted index.
  - Wrap-around: with ptr=CHANNELS-1, the search starts at channel 0.
- Requests that are not granted are not dropped. The producer must hold IN_VALID and IN_DATA until it sees IN_READY.
- A channel never receives IN_READY when its IN_VALID is low.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, ptr=CHANNELS-1 (so channel 0 is first after reset). IN_READY is 0 while RST is high.
- RST assertion mid-transfer clears the stage immediately (asynchronously); any word in the output register is discarded.
- Latency is 1 cycle from the IN_VALID/IN_READY edge to OUT_VALID.
- Sustained throughput is 1 word per cycle while OUT_READY=1.
- IN_READY has a combinational path from IN_VALID and OUT_READY. There is no combinational path from any input to OUT_DATA, OUT_SEL or OUT_VALID.

## Structure
- Shared package/header holds the mode constants ARB_FIXED=0 and ARB_RR=1, plus the $clog2-based width helper used by SELW.
- Sub-module rr_arbiter_n(CHANNELS, MODE) contains the combinational grant logic and the ptr register; it exposes grant one-hot plus grant index.
- The top level contains the output register, the load_en logic and data selection. Selection is an indexed part-select from the grant index.

## Test plan
- Reset: hold RST for 2 cycles with all IN_VALID=1 -> IN_READY=0000, OUT_VALID=0, OUT_DATA=0. After release, first grant is channel 0 and OUT_SEL=0 on the next cycle.
- Round-robin fairness: BITS=4, CHANNELS=4, MODE=1, all valid with data 0xA,0xB,0xC,0xD, OUT_READY=1 -> OUT_DATA sequence A,B,C,D,A with OUT_SEL 0,1,2,3,0 (wrap verified), one word per cycle.
- Fixed priority: MODE=0, channels 1 and 3 valid continuously -> channel 1 is always granted and channel 3 IN_READY never rises. When channel 1 drops, channel 3 is granted next cycle.
- Backpressure: OUT_READY=0 for 5 cycles after a load of 0x7 from channel 2 -> OUT_DATA=0x7, OUT_SEL=2, OUT_VALID=1 stable, all IN_READY=0. OUT_READY=1 with channel 0 valid -> drain and load on the same edge, OUT_VALID stays 1.
- Drain to empty: a single word, then no IN_VALID, with OUT_READY=1 -> OUT_VALID falls after one cycle and OUT_DATA holds its last value.
- Reset mid-operation: assert RST asynchronously while OUT_VALID=1 with ptr=2 -> OUT_VALID=0 immediately. After release, all-valid grants channel 0 first.
